// File: rtl/tick_timer_pkg.sv
// Shared types and constants for the tick-driven countdown timer.
package tick_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HOLD   = 2'd2,
    EXPIRE = 2'd3
  } tick_timer_state_t;

  localparam int TICK_TIMER_W_DEF = 8;

endpackage

// File: rtl/tick_timer_rise_detect.sv
// Rising-edge qualifier for a level input that is already synchronous to clk.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= 1'b0;
    else        q <= d;
  end

  assign rise = d & ~q;

endmodule

// File: rtl/tick_timer.sv
// Countdown timer driven by rising edges of tick_in; pulses expired on reaching zero.
// Optional auto-reload mode is enabled by defining TICK_TIMER_PERIODIC_EN.
module tick_timer
  import tick_timer_pkg::*;
#(
  parameter int W = TICK_TIMER_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick_in,
  input  logic [W-1:0] load_val,
  input  logic         start,
  input  logic         hold,
  input  logic         abort,
`ifdef TICK_TIMER_PERIODIC_EN
  input  logic         periodic,
`endif
  output logic [W-1:0] remaining,
  output logic         busy,
  output logic         expired
);

  tick_timer_state_t state, next_state;
  logic tick_rise;
  logic do_load, do_dec, do_clear, do_reload;

  rise_detect u_rise (
    .clk   (clk),
    .reset (reset),
    .d     (tick_in),
    .rise  (tick_rise)
  );

`ifdef TICK_TIMER_PERIODIC_EN
  logic [W-1:0] reload;
  logic         periodic_arm;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Priority is abort, then start, then hold, then the tick edge.
  always_comb begin
    next_state = state;
    do_load    = 1'b0;
    do_dec     = 1'b0;
    do_clear   = 1'b0;
    do_reload  = 1'b0;
    if (abort) begin
      next_state = IDLE;
      do_clear   = 1'b1;
    end else if (start) begin
      do_load    = 1'b1;
      next_state = (load_val != '0) ? RUN : EXPIRE;
    end else begin
      case (state)
        IDLE: next_state = IDLE;
        RUN: begin
          if (hold) begin
            next_state = HOLD;
          end else if (tick_rise) begin
            do_dec = 1'b1;
            if (remaining == W'(1)) next_state = EXPIRE;
          end
        end
        HOLD: begin
          if (!hold) next_state = RUN;
        end
        EXPIRE: begin
          next_state = IDLE;
`ifdef TICK_TIMER_PERIODIC_EN
          if (periodic && (reload != '0)) begin
            next_state = RUN;
            do_reload  = 1'b1;
          end
`endif
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         remaining <= '0;
    else if (do_clear)  remaining <= '0;
    else if (do_load)   remaining <= load_val;
`ifdef TICK_TIMER_PERIODIC_EN
    else if (do_reload) remaining <= reload;
`endif
    else if (do_dec)    remaining <= remaining - W'(1);
  end

`ifdef TICK_TIMER_PERIODIC_EN
  // periodic_arm keeps busy high through an expiry that will reload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reload       <= '0;
      periodic_arm <= 1'b0;
    end else begin
      if (do_load) reload <= load_val;
      periodic_arm <= (next_state == EXPIRE) && !do_load && periodic && (reload != '0);
    end
  end
`endif

  always_comb begin
    busy    = (state == RUN) || (state == HOLD);
    expired = (state == EXPIRE);
`ifdef TICK_TIMER_PERIODIC_EN
    if (state == EXPIRE && periodic_arm) busy = 1'b1;
`endif
  end

endmodule
